// File: rtl/spm_dp_pkg.sv
// Shared types and constants for the dual-port scratch-pad memory.
// Clear FSM encodings, bus strobe/direction levels and collision-mode selectors.
package spm_dp_pkg;

  localparam int SPM_WORD_W = 32;
  localparam int SPM_DEPTH  = 4096;
  localparam int SPM_ADDR_W = $clog2(SPM_DEPTH);

  localparam logic SPM_READ    = 1'b1;
  localparam logic SPM_WRITE   = 1'b0;
  localparam logic SPM_ENABLE_ = 1'b0;

  localparam int SPM_COLL_NEW = 0;
  localparam int SPM_COLL_OLD = 1;

  typedef enum logic {
    SPM_ST_IDLE  = 1'b0,
    SPM_ST_CLEAR = 1'b1
  } spm_state_e;

endpackage

// File: rtl/spm_dp_if.sv
// One scratch-pad access port: active-low strobe, direction, byte enables, read return.
// The master drives requests; the slave (memory) returns registered read data with a valid flag.
interface spm_dp_if
  import spm_dp_pkg::*;
#(
  parameter int WORD_W = SPM_WORD_W,
  parameter int ADDR_W = SPM_ADDR_W
);
  logic                  as_;
  logic                  rw;
  logic [ADDR_W-1:0]     addr;
  logic [WORD_W/8-1:0]   be;
  logic [WORD_W-1:0]     wr_data;
  logic [WORD_W-1:0]     rd_data;
  logic                  rd_valid;

  modport master (
    output as_, rw, addr, be, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  as_, rw, addr, be, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/spm_dp_lane.sv
// One 8-bit true-dual-port RAM lane; synchronous read-before-write, one-cycle read latency.
// Read registers hold between reads; x_fwd_i returns the other port's same-cycle write byte instead.
module spm_dp_lane
  import spm_dp_pkg::*;
#(
  parameter int DEPTH  = SPM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_re_i,
  input  logic              a_we_i,
  input  logic              a_fwd_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [7:0]        a_wd_i,
  output logic [7:0]        a_rd_o,
  input  logic              b_re_i,
  input  logic              b_we_i,
  input  logic              b_fwd_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [7:0]        b_wd_i,
  output logic [7:0]        b_rd_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] a_rd_q, b_rd_q;

  // The top never lets both ports write the same lane at the same address.
  always_ff @(posedge clk) begin
    if (a_we_i) mem_q[a_addr_i] <= a_wd_i;
    if (b_we_i) mem_q[b_addr_i] <= b_wd_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else begin
      if (a_re_i) a_rd_q <= a_fwd_i ? b_wd_i : mem_q[a_addr_i];
      if (b_re_i) b_rd_q <= b_fwd_i ? a_wd_i : mem_q[b_addr_i];
    end
  end

  assign a_rd_o = a_rd_q;
  assign b_rd_o = b_rd_q;

endmodule

// File: rtl/spm_dp.sv
// Dual-port byte-enabled scratch-pad with collision resolution and a hardware clear engine.
// Read data valid RD_LAT (1/2) cycles after the strobe; no backpressure, but strobes are dropped while clearing.
module spm_dp
  import spm_dp_pkg::*;
#(
  parameter int WORD_W    = SPM_WORD_W,
  parameter int DEPTH     = SPM_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int RD_LAT    = 1,
  parameter int COLL_MODE = SPM_COLL_NEW
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr_req,
  output logic     clr_busy,
  spm_dp_if.slave  a,
  spm_dp_if.slave  b,
  output logic     coll
);

  localparam int NB      = WORD_W / 8;
  localparam bit FWD_NEW = (COLL_MODE != SPM_COLL_OLD);

  spm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              idle, clearing;
  logic              a_acc, b_acc, a_rd, a_wr, b_rd, b_wr, hit, ww;
  logic [NB-1:0]     a_we, b_we, a_fwd, b_fwd;
  logic [ADDR_W-1:0] b_addr_m;
  logic [WORD_W-1:0] b_wd_m, a_ram_rd, b_ram_rd;
  logic              a_v1_q, b_v1_q, coll_q;

  assign idle     = (state_q == SPM_ST_IDLE);
  assign clearing = ~idle;

  assign a_acc = idle && (a.as_ == SPM_ENABLE_);
  assign b_acc = idle && (b.as_ == SPM_ENABLE_);
  assign a_rd  = a_acc && (a.rw == SPM_READ);
  assign a_wr  = a_acc && (a.rw == SPM_WRITE);
  assign b_rd  = b_acc && (b.rw == SPM_READ);
  assign b_wr  = b_acc && (b.rw == SPM_WRITE);

  assign hit = a_acc && b_acc && (a.addr == b.addr);
  assign ww  = hit && a_wr && b_wr;

  // Byte-granular forwarding of the other port's write; lanes not written keep old data.
  assign a_fwd = (FWD_NEW && hit && a_rd && b_wr) ? b.be : '0;
  assign b_fwd = (FWD_NEW && hit && b_rd && a_wr) ? a.be : '0;

  // W/W on the same word: B owns every lane both ports enable.
  assign a_we = a_wr ? (a.be & ~(ww ? b.be : '0)) : '0;

  // Port B of the RAM belongs to the clear engine while it runs.
  assign b_we     = clearing ? '1 : (b_wr ? b.be : '0);
  assign b_addr_m = clearing ? clr_cnt_q : b.addr;
  assign b_wd_m   = clearing ? '0 : b.wr_data;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    spm_dp_lane #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_re_i   (a_rd),
      .a_we_i   (a_we[i]),
      .a_fwd_i  (a_fwd[i]),
      .a_addr_i (a.addr),
      .a_wd_i   (a.wr_data[8*i +: 8]),
      .a_rd_o   (a_ram_rd[8*i +: 8]),
      .b_re_i   (b_rd),
      .b_we_i   (b_we[i]),
      .b_fwd_i  (b_fwd[i]),
      .b_addr_i (b_addr_m),
      .b_wd_i   (b_wd_m[8*i +: 8]),
      .b_rd_o   (b_ram_rd[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SPM_ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      SPM_ST_IDLE: begin
        if (clr_req) state_d = SPM_ST_CLEAR;
      end
      SPM_ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          clr_cnt_d = '0;
          state_d   = SPM_ST_IDLE;
        end
      end
      default: state_d = SPM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      a_v1_q <= a_rd;
      b_v1_q <= b_rd;
      coll_q <= hit && (a_wr || b_wr);
    end
  end

  assign coll     = coll_q;
  assign clr_busy = clearing;

  if (RD_LAT == 2) begin : g_lat2
    logic              a_v2_q, b_v2_q;
    logic [WORD_W-1:0] a_dat_q, b_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_v2_q  <= 1'b0;
        b_v2_q  <= 1'b0;
        a_dat_q <= '0;
        b_dat_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        if (a_v1_q) a_dat_q <= a_ram_rd;
        if (b_v1_q) b_dat_q <= b_ram_rd;
      end
    end

    assign a.rd_valid = a_v2_q;
    assign a.rd_data  = a_dat_q;
    assign b.rd_valid = b_v2_q;
    assign b.rd_data  = b_dat_q;
  end else begin : g_lat1
    assign a.rd_valid = a_v1_q;
    assign a.rd_data  = a_ram_rd;
    assign b.rd_valid = b_v1_q;
    assign b.rd_data  = b_ram_rd;
  end

endmodule

// File: tb/tb_spm_dp.sv
// Directed bench: two spm_dp copies (RD_LAT=1/write-first and RD_LAT=2/old-data) share one stimulus stream.
module tb_spm_dp;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int OI = 0, ORD = 1, OWR = 2;

  logic clk, rst_n, clr_req;
  logic busy0, busy1, coll0, coll1;
  logic          a_as, a_rw, b_as, b_rw;
  logic [AW-1:0] a_ad, b_ad;
  logic [3:0]    a_be, b_be;
  logic [31:0]   a_wd, b_wd;

  int n_run  = 0;
  int n_fail = 0;

  spm_dp_if #(.WORD_W(32), .ADDR_W(AW)) a0 ();
  spm_dp_if #(.WORD_W(32), .ADDR_W(AW)) b0 ();
  spm_dp_if #(.WORD_W(32), .ADDR_W(AW)) a1 ();
  spm_dp_if #(.WORD_W(32), .ADDR_W(AW)) b1 ();

  assign a0.as_ = a_as;  assign a1.as_ = a_as;
  assign a0.rw = a_rw;   assign a1.rw = a_rw;
  assign a0.addr = a_ad; assign a1.addr = a_ad;
  assign a0.be = a_be;   assign a1.be = a_be;
  assign a0.wr_data = a_wd; assign a1.wr_data = a_wd;
  assign b0.as_ = b_as;  assign b1.as_ = b_as;
  assign b0.rw = b_rw;   assign b1.rw = b_rw;
  assign b0.addr = b_ad; assign b1.addr = b_ad;
  assign b0.be = b_be;   assign b1.be = b_be;
  assign b0.wr_data = b_wd; assign b1.wr_data = b_wd;

  spm_dp #(.WORD_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(1), .COLL_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy0), .a(a0), .b(b0), .coll(coll0));
  spm_dp #(.WORD_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(2), .COLL_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy1), .a(a1), .b(b1), .coll(coll1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          a_op;
    logic [AW-1:0] a_ad;
    logic [3:0]  a_be;
    logic [31:0] a_wd;
    int          b_op;
    logic [AW-1:0] b_ad;
    logic [3:0]  b_be;
    logic [31:0] b_wd;
    logic [31:0] ea0, ea1, eb0, eb1;
    logic        ec;
  } vec_t;

  typedef struct {
    logic        rd_a, rd_b;
    logic [31:0] ea0, ea1, eb0, eb1;
  } hist_t;

  vec_t  vecs[$];
  vec_t  idle_v;
  hist_t h0, h1;

  function automatic vec_t mk(input int aop, input int aad, input logic [3:0] abe, input logic [31:0] awd,
                              input int bop, input int bad, input logic [3:0] bbe, input logic [31:0] bwd,
                              input logic [31:0] ea0, input logic [31:0] ea1,
                              input logic [31:0] eb0, input logic [31:0] eb1, input logic ec);
    vec_t v;
    v.a_op = aop; v.a_ad = AW'(aad); v.a_be = abe; v.a_wd = awd;
    v.b_op = bop; v.b_ad = AW'(bad); v.b_be = bbe; v.b_wd = bwd;
    v.ea0 = ea0; v.ea1 = ea1; v.eb0 = eb0; v.eb1 = eb1; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // acc=0 marks cycles where the DUT must ignore the strobes (clear running).
  task automatic step(input vec_t v, input bit acc);
    a_as = (v.a_op == OI); a_rw = (v.a_op == ORD); a_ad = v.a_ad; a_be = v.a_be; a_wd = v.a_wd;
    b_as = (v.b_op == OI); b_rw = (v.b_op == ORD); b_ad = v.b_ad; b_be = v.b_be; b_wd = v.b_wd;
    @(posedge clk);
    h1 = h0;
    h0.rd_a = acc && (v.a_op == ORD);
    h0.rd_b = acc && (v.b_op == ORD);
    h0.ea0 = v.ea0; h0.ea1 = v.ea1; h0.eb0 = v.eb0; h0.eb1 = v.eb1;
    #1;
    chk("a_vld_lat1", a0.rd_valid, h0.rd_a);
    if (h0.rd_a) chk("a_dat_lat1", a0.rd_data, h0.ea0);
    chk("b_vld_lat1", b0.rd_valid, h0.rd_b);
    if (h0.rd_b) chk("b_dat_lat1", b0.rd_data, h0.eb0);
    chk("a_vld_lat2", a1.rd_valid, h1.rd_a);
    if (h1.rd_a) chk("a_dat_lat2", a1.rd_data, h1.ea1);
    chk("b_vld_lat2", b1.rd_valid, h1.rd_b);
    if (h1.rd_b) chk("b_dat_lat2", b1.rd_data, h1.eb1);
    chk("coll_new", coll0, acc && v.ec);
    chk("coll_old", coll1, acc && v.ec);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy0"}, busy0, 0);   chk({nm, "_busy1"}, busy1, 0);
    chk({nm, "_coll0"}, coll0, 0);   chk({nm, "_coll1"}, coll1, 0);
    chk({nm, "_avld0"}, a0.rd_valid, 0); chk({nm, "_bvld0"}, b0.rd_valid, 0);
    chk({nm, "_avld1"}, a1.rd_valid, 0); chk({nm, "_bvld1"}, b1.rd_valid, 0);
    chk({nm, "_adat0"}, a0.rd_data, 0);  chk({nm, "_bdat0"}, b0.rd_data, 0);
    chk({nm, "_adat1"}, a1.rd_data, 0);  chk({nm, "_bdat1"}, b1.rd_data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    idle_v = mk(OI, 0, 0, 0, OI, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(OWR, i, 4'hF, 32'(255 - i), OI, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(OI, 0, 0, 0, ORD, i, 0, 0, 0, 0, 32'(255 - i), 32'(255 - i), 0));
    vecs.push_back(mk(OWR, 5, 4'hF, 32'hFFFF_FFFF, OI, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OWR, 5, 4'b0101, 32'h1122_3344, OI, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(ORD, 5, 0, 0, OI, 0, 0, 0, 32'hFF22_FF44, 32'hFF22_FF44, 0, 0, 0));
    vecs.push_back(mk(OWR, 7, 4'hF, 0, OI, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(ORD, 7, 0, 0, OWR, 7, 4'hF, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0, 0, 0, 1));
    vecs.push_back(mk(ORD, 7, 0, 0, OI, 0, 0, 0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0, 0, 0));
    vecs.push_back(mk(OWR, 9, 4'hF, 32'h5566_7788, OI, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OWR, 9, 4'b0011, 32'h1111_1111, OWR, 9, 4'b0110, 32'h2222_2222, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OI, 0, 0, 0, ORD, 9, 0, 0, 0, 0, 32'h5522_2211, 32'h5522_2211, 0));
    vecs.push_back(mk(OI, 0, 0, 0, OWR, 10, 4'hF, 32'h0102_0304, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OWR, 10, 4'b1001, 32'hDEAD_BEEF, ORD, 10, 0, 0, 0, 0, 32'hDE02_03EF, 32'h0102_0304, 1));
    vecs.push_back(mk(ORD, 10, 0, 0, ORD, 10, 0, 0, 32'hDE02_03EF, 32'hDE02_03EF, 32'hDE02_03EF, 32'hDE02_03EF, 0));
    vecs.push_back(mk(OWR, 20, 4'hF, 32'hCAFE_F00D, OWR, 21, 4'hF, 32'h0BAD_BEEF, 0, 0, 0, 0, 0));
    vecs.push_back(mk(ORD, 21, 0, 0, ORD, 20, 0, 0, 32'h0BAD_BEEF, 32'h0BAD_BEEF, 32'hCAFE_F00D, 32'hCAFE_F00D, 0));
    vecs.push_back(mk(OWR, 10, 4'h0, 32'hFFFF_FFFF, OI, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OI, 0, 0, 0, ORD, 10, 0, 0, 0, 0, 32'hDE02_03EF, 32'hDE02_03EF, 0));

    h0 = '{default: '0};
    h1 = '{default: '0};
    rst_n = 1'b0; clr_req = 1'b0;
    a_as = 1'b1; a_rw = 1'b1; a_ad = '0; a_be = '0; a_wd = '0;
    b_as = 1'b1; b_rw = 1'b1; b_ad = '0; b_be = '0; b_wd = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], 1'b1);
    repeat (2) step(idle_v, 1'b1);
    chk("hold_a0", a0.rd_data, 32'h0BAD_BEEF);
    chk("hold_b0", b0.rd_data, 32'hDE02_03EF);
    chk("hold_b1", b1.rd_data, 32'hDE02_03EF);

    // Full clear: fill, clear with a same-cycle read, strobes and a second clr_req ignored meanwhile.
    for (int i = 0; i < DEPTH; i++)
      step(mk(OWR, i, 4'hF, 32'hA500_0000 | 32'(i), OI, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    clr_req = 1'b1;
    step(mk(OI, 0, 0, 0, ORD, 3, 0, 0, 0, 0, 32'hA500_0003, 32'hA500_0003, 0), 1'b1);
    clr_req = 1'b0;
    chk("busy0_c1", busy0, 1); chk("busy1_c1", busy1, 1);
    for (int c = 1; c < DEPTH; c++) begin
      if (c == DEPTH / 4) clr_req = 1'b1;
      step(mk(OWR, 3, 4'hF, 32'hFFFF_FFFF, ORD, 3, 0, 0, 0, 0, 0, 0, 1), 1'b0);
      clr_req = 1'b0;
      chk("busy0_clr", busy0, 1); chk("busy1_clr", busy1, 1);
    end
    step(idle_v, 1'b1);
    chk("busy0_end", busy0, 0); chk("busy1_end", busy1, 0);
    for (int i = 0; i < DEPTH; i++)
      step(mk(ORD, i, 0, 0, ORD, DEPTH - 1 - i, 0, 0, 0, 0, 0, 0, 0), 1'b1);

    // Reset half-way through a clear.
    step(mk(OWR, 0, 4'hF, 32'h1234_5678, OWR, DEPTH - 1, 4'hF, 32'h8765_4321, 0, 0, 0, 0, 0), 1'b1);
    step(mk(ORD, 0, 0, 0, ORD, DEPTH - 1, 0, 0, 32'h1234_5678, 32'h1234_5678, 32'h8765_4321, 32'h8765_4321, 0), 1'b1);
    clr_req = 1'b1;
    step(idle_v, 1'b1);
    clr_req = 1'b0;
    for (int c = 1; c < DEPTH / 2; c++) step(idle_v, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midclr_rst");
    h0 = '{default: '0};
    h1 = '{default: '0};
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(ORD, 0, 0, 0, ORD, DEPTH - 1, 0, 0, 0, 0, 32'h8765_4321, 32'h8765_4321, 0), 1'b1);
    repeat (2) step(idle_v, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
